// File: rtl/chan_block_fifo_pkg.sv
// Shared constants for the per-channel block FIFO and the arbitter that
// consumes it (the arbitter bus is 16 x CFIFO_DATA_WIDTH wide).
package chan_block_fifo_pkg;

    localparam int          CFIFO_DATA_WIDTH = 16;
    localparam int          CFIFO_ADDR_WIDTH = 11;
    localparam logic [15:0] CFIFO_OVF_MAX    = 16'hFFFF;

endpackage

// File: rtl/chan_fifo_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM.
module chan_fifo_ram
    import chan_block_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = CFIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = CFIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port and registered read port share the system clock.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/chan_block_fifo.sv
// Per-channel block FIFO feeding the arbitter. Words are only exposed once
// their block has been closed by wlast; an overflowing block is rewound
// away whole and counted in ovf_cnt.
//
// Pointers: wptr (next write), cptr (end of last committed block),
// rptr (next RAM read issue), aptr (next word to be acked). rptr runs
// ahead of aptr by the words sitting in the read pipeline/output stage;
// those slots are already copied out of the RAM so they count as free.
module chan_block_fifo
    import chan_block_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = CFIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = CFIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  we,
    input  logic                  wlast,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  req,
    input  logic                  ack,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic [15:0]           ovf_cnt
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   wptr, cptr, rptr, aptr;
    logic [ADDR_WIDTH:0]   wptr_inc;
    logic                  drop;
    logic                  ram_we, ram_re;
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  rd_v;
    logic                  out_v, skid_v;
    logic [DATA_WIDTH-1:0] out_d, skid_d;
    logic                  pop;
    logic [1:0]            occ;

    assign wptr_inc = wptr + 1'b1;
    assign full     = (wptr - rptr) == DEPTH;
    assign ram_we   = we && !drop && !full;

    // Words held or in flight towards the output stage; a new RAM read is
    // issued only when it is guaranteed a slot after this clock's pop.
    assign pop    = out_v && ack;
    assign occ    = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, rd_v};
    assign ram_re = (rptr != cptr) && ((occ - {1'b0, pop}) < 2'd2);

    assign req   = out_v;
    assign dout  = out_d;
    assign level = cptr - aptr;

    chan_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .re    (ram_re),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (rd_d)
    );

    // Write side: store, commit on wlast, or drop and rewind an overflowing block.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            cptr    <= '0;
            drop    <= 1'b0;
            ovf_cnt <= '0;
        end else if (we) begin
            if (drop || full) begin
                if (wlast) begin
                    wptr <= cptr;
                    drop <= 1'b0;
                    if (ovf_cnt != CFIFO_OVF_MAX) ovf_cnt <= ovf_cnt + 16'd1;
                end else begin
                    drop <= 1'b1;
                end
            end else begin
                wptr <= wptr_inc;
                if (wlast) cptr <= wptr_inc;
            end
        end
    end

    // Read side: RAM read issue plus the two-entry output/skid stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr   <= '0;
            aptr   <= '0;
            rd_v   <= 1'b0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_d  <= '0;
            skid_d <= '0;
        end else begin
            rd_v <= ram_re;
            if (ram_re) rptr <= rptr + 1'b1;
            if (pop)    aptr <= aptr + 1'b1;
            if (!out_v || pop) begin
                if (skid_v) begin
                    out_d  <= skid_d;
                    out_v  <= 1'b1;
                    skid_d <= rd_d;
                    skid_v <= rd_v;
                end else if (rd_v) begin
                    out_d <= rd_d;
                    out_v <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (rd_v) begin
                skid_d <= rd_d;
                skid_v <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chan_block_fifo.sv
// Directed bench for chan_block_fifo. Expected words are queued by the bench
// when it commits a block; every acked word is compared against that queue.
module tb_chan_block_fifo;

    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          we = 1'b0;
    logic          wlast = 1'b0;
    logic [DW-1:0] dout;
    logic          req;
    logic          ack = 1'b0;
    logic          full;
    logic [AW:0]   level;
    logic [15:0]   ovf_cnt;

    int            checks = 0;
    int            errors = 0;
    int            rx_cnt = 0;
    int            stab_err = 0;
    bit            full_seen = 1'b0;
    bit            rand_ack = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] blk[$];

    chan_block_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .we      (we),
        .wlast   (wlast),
        .dout    (dout),
        .req     (req),
        .ack     (ack),
        .full    (full),
        .level   (level),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: consumes a word if req&ack held before the edge, checks hold stability.
    task automatic tick();
        logic          pop_q;
        logic          hold_q;
        logic [DW-1:0] d_q;
        pop_q  = req && ack && !reset;
        hold_q = req && !ack && !reset;
        d_q    = dout;
        @(posedge clk);
        #1;
        if (full) full_seen = 1'b1;
        if (hold_q && (!req || dout !== d_q)) stab_err++;
        if (pop_q) begin
            if (exp_q.size() == 0) chk("extra_word_queue_size", 32'(exp_q.size()), 32'd1);
            else begin
                chk("data", 32'(d_q), 32'(exp_q.pop_front()));
                rx_cnt++;
            end
        end
        if (rand_ack) ack = 1'($urandom_range(0, 1));
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic last);
        din   = d;
        we    = 1'b1;
        wlast = last;
        tick();
        we    = 1'b0;
        wlast = 1'b0;
    endtask

    // Writes n words starting at base; wlast on the final one if commit is set.
    task automatic write_block(input logic [DW-1:0] base, input int n, input bit commit);
        for (int i = 0; i < n; i++) begin
            if (commit && i == n - 1) begin
                for (int j = 0; j < n; j++) exp_q.push_back(base + DW'(j));
            end
            write_word(base + DW'(i), commit && (i == n - 1));
        end
    endtask

    task automatic drain(input string tag, input int start, input int n);
        int budget;
        budget = 5000;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
        tick();
        chk({tag, "_count"}, 32'(rx_cnt - start), 32'(n));
        chk({tag, "_req_end"}, 32'(req), 32'd0);
        chk({tag, "_level_end"}, 32'(level), 32'd0);
    endtask

    initial begin
        int start;
        int bubbles;

        // Reset state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);

        // Basic: 10-word block, ack held high
        ack   = 1'b1;
        start = rx_cnt;
        write_block(16'h0000, 10, 1'b1);
        chk("basic_level_commit", 32'(level), 32'd10);
        chk("basic_req_n0", 32'(req), 32'd0);
        tick();
        chk("basic_req_n1", 32'(req), 32'd0);
        tick();
        chk("basic_req_n2", 32'(req), 32'd1);
        chk("basic_dout_n2", 32'(dout), 32'h0000);
        chk("basic_level_n2", 32'(level), 32'd10);
        bubbles = 0;
        for (int i = 0; i < 10; i++) begin
            if (!req) bubbles++;
            tick();
        end
        chk("basic_bubbles", 32'(bubbles), 32'd0);
        chk("basic_count", 32'(rx_cnt - start), 32'd10);
        chk("basic_req_end", 32'(req), 32'd0);
        chk("basic_level_end", 32'(level), 32'd0);

        // Uncommitted words stay invisible
        start = rx_cnt;
        for (int i = 0; i < 5; i++) write_word(16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("uncommit_req", 32'(req), 32'd0);
        chk("uncommit_level", 32'(level), 32'd0);
        for (int j = 0; j < 6; j++) exp_q.push_back(16'h0100 + 16'(j));
        write_word(16'h0105, 1'b1);
        chk("uncommit_level_commit", 32'(level), 32'd6);
        drain("uncommit", start, 6);

        // Simultaneous commit and ack: level moves by block length - 1
        ack   = 1'b0;
        start = rx_cnt;
        write_block(16'h0200, 3, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("simul_req", 32'(req), 32'd1);
        chk("simul_level_a", 32'(level), 32'd3);
        for (int j = 0; j < 4; j++) exp_q.push_back(16'h0300 + 16'(j));
        for (int i = 0; i < 3; i++) write_word(16'h0300 + 16'(i), 1'b0);
        ack = 1'b1;
        write_word(16'h0303, 1'b1);
        chk("simul_level_b", 32'(level), 32'd6);
        drain("simul", start, 7);

        // Overflow: 2048 words fill the buffer, word 2049 dropped, wlast on 2050
        ack = 1'b0;
        for (int i = 0; i < 2048; i++) write_word(DW'(i), 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        write_word(16'hEEEE, 1'b0);
        write_word(16'hEEEF, 1'b1);
        chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("ovf_level", 32'(level), 32'd0);
        chk("ovf_full_after", 32'(full), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("ovf_req", 32'(req), 32'd0);
        ack   = 1'b1;
        start = rx_cnt;
        write_block(16'h00A0, 4, 1'b1);
        drain("ovf_next", start, 4);

        // Backpressure: random ack over a 300-word block
        stab_err = 0;
        rand_ack = 1'b1;
        start    = rx_cnt;
        write_block(16'h1000, 300, 1'b1);
        drain("bp", start, 300);
        rand_ack = 1'b0;
        chk("bp_dout_stable", 32'(stab_err), 32'd0);

        // Wrap: three 1000-word blocks with concurrent reads
        ack       = 1'b1;
        full_seen = 1'b0;
        start     = rx_cnt;
        write_block(16'h2000, 1000, 1'b1);
        write_block(16'h4000, 1000, 1'b1);
        write_block(16'h6000, 1000, 1'b1);
        drain("wrap", start, 3000);
        chk("wrap_full_seen", 32'(full_seen), 32'd0);

        // Reset mid-block: 600 committed, 100 pending
        ack = 1'b0;
        write_block(16'h8000, 600, 1'b1);
        write_block(16'h9000, 100, 1'b0);
        chk("mid_level_pre", 32'(level), 32'd600);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("mid_req", 32'(req), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_ovf", 32'(ovf_cnt), 32'd0);
        chk("mid_dout", 32'(dout), 32'd0);
        ack   = 1'b1;
        start = rx_cnt;
        write_block(16'h0ABC, 3, 1'b1);
        drain("mid_next", start, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always reaches its summary.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
